data_mem_read_sched: RTL and testbench

// - Read scheduler for the dual-port input tile memory (128 x 512b words, one pre-sliced Winograd input tile per word).
// - Walks a configured run of tile addresses and drives the memory's two read ports at two tiles/cycle.
// - Repeats the run for each output-channel pass (weight-reuse loop).
// - Holds requests under downstream backpressure; yields to scan loading.

---
 rtl/wino_mem_pkg.sv | 12 +
 rtl/data_mem_read_sched_tile_addr_gen.sv | 55 +++++
 rtl/data_mem_read_sched.sv | 151 +++++++++++++++
 tb/tb_data_mem_read_sched.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wino_mem_pkg.sv
// Shared constants and state encoding for the Winograd input-tile memory read scheduler.
package wino_mem_pkg;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 128;
    localparam int PASS_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DONE
    } sched_state_t;
endpackage

// File: rtl/data_mem_read_sched_tile_addr_gen.sv
// Tile counter plus the wrapped address pair, valid pair and last flag for the package
// that the counter will point at after this cycle's clear/advance.
module tile_addr_gen
    import wino_mem_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              advance,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] num_tiles,
    output logic [ADDR_W-1:0] addr_1,
    output logic [ADDR_W-1:0] addr_2,
    output logic              valid_1,
    output logic              valid_2,
    output logic              last
);
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

    logic [ADDR_W-1:0] cnt_reg;
    logic [ADDR_W-1:0] cnt_next;
    logic [ADDR_W-1:0] rem;
    logic [ADDR_W:0]   sum  [2];
    logic [ADDR_W:0]   wrap [2];

    always_comb begin
        cnt_next = cnt_reg;
        if (clear) begin
            cnt_next = '0;
        end else if (advance) begin
            cnt_next = cnt_reg + ADDR_W'(2);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    // One extra bit keeps base+cnt+1 exact before the modulo reduction.
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        assign sum[gi]  = {1'b0, base} + {1'b0, cnt_next} + (ADDR_W+1)'(gi);
        assign wrap[gi] = sum[gi] % DEPTH_X;
    end

    assign rem     = num_tiles - cnt_next;
    assign valid_1 = (rem != '0);
    assign valid_2 = (rem >= ADDR_W'(2));
    assign last    = (rem <= ADDR_W'(2));
    assign addr_1  = wrap[0][ADDR_W-1:0];
    assign addr_2  = valid_2 ? wrap[1][ADDR_W-1:0] : wrap[0][ADDR_W-1:0];
endmodule

// File: rtl/data_mem_read_sched.sv
// Read scheduler: walks a tile run two addresses per cycle on the dual-port tile memory,
// repeating it once per output-channel pass, with backpressure hold and scan-load abort.
module data_mem_read_sched
    import wino_mem_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [ADDR_W-1:0] cfg_num_tiles,
    input  logic [PASS_W-1:0] cfg_num_passes,
    input  logic              scan_mode,
    input  logic              ready_in,
    output logic [ADDR_W-1:0] addr_1_out,
    output logic [ADDR_W-1:0] addr_2_out,
    output logic              package_1_valid_out,
    output logic              package_2_valid_out,
    output logic              last_out,
    output logic [PASS_W-1:0] pass_idx_out,
    output logic              busy,
    output logic              done
);
    sched_state_t      state_reg;
    logic [ADDR_W-1:0] base_reg;
    logic [ADDR_W-1:0] num_tiles_reg;
    logic [PASS_W-1:0] num_passes_reg;
    logic [PASS_W-1:0] pass_reg;
    logic [ADDR_W-1:0] addr_1_reg;
    logic [ADDR_W-1:0] addr_2_reg;
    logic              valid_1_reg;
    logic              valid_2_reg;
    logic              last_reg;
    logic              busy_reg;
    logic              done_reg;

    logic              start_ok;
    logic              accept;
    logic              gen_clear;
    logic              gen_advance;
    logic [ADDR_W-1:0] gen_base;
    logic [ADDR_W-1:0] gen_num_tiles;
    logic [ADDR_W-1:0] gen_addr_1;
    logic [ADDR_W-1:0] gen_addr_2;
    logic              gen_valid_1;
    logic              gen_valid_2;
    logic              gen_last;

    assign start_ok    = (state_reg == IDLE) && start && !scan_mode;
    assign accept      = (state_reg == ISSUE) && valid_1_reg && ready_in && !scan_mode;
    assign gen_clear   = start_ok || (accept && last_reg);
    assign gen_advance = accept && !last_reg;

    // In IDLE the generator looks straight at cfg so the first package registers on the start edge.
    assign gen_base      = (state_reg == IDLE) ? cfg_base      : base_reg;
    assign gen_num_tiles = (state_reg == IDLE) ? cfg_num_tiles : num_tiles_reg;

    tile_addr_gen u_addr_gen (
        .clk       (clk),
        .reset     (reset),
        .clear     (gen_clear),
        .advance   (gen_advance),
        .base      (gen_base),
        .num_tiles (gen_num_tiles),
        .addr_1    (gen_addr_1),
        .addr_2    (gen_addr_2),
        .valid_1   (gen_valid_1),
        .valid_2   (gen_valid_2),
        .last      (gen_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            base_reg       <= '0;
            num_tiles_reg  <= '0;
            num_passes_reg <= '0;
            pass_reg       <= '0;
            addr_1_reg     <= '0;
            addr_2_reg     <= '0;
            valid_1_reg    <= 1'b0;
            valid_2_reg    <= 1'b0;
            last_reg       <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start_ok) begin
                        base_reg       <= cfg_base;
                        num_tiles_reg  <= cfg_num_tiles;
                        num_passes_reg <= cfg_num_passes;
                        pass_reg       <= '0;
                        busy_reg       <= 1'b1;
                        if (cfg_num_tiles != '0 && cfg_num_passes != '0) begin
                            state_reg   <= ISSUE;
                            addr_1_reg  <= gen_addr_1;
                            addr_2_reg  <= gen_addr_2;
                            valid_1_reg <= gen_valid_1;
                            valid_2_reg <= gen_valid_2;
                            last_reg    <= gen_last;
                        end else begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (scan_mode || (accept && last_reg &&
                                      pass_reg == num_passes_reg - PASS_W'(1))) begin
                        state_reg   <= scan_mode ? IDLE : DONE;
                        busy_reg    <= !scan_mode;
                        done_reg    <= !scan_mode;
                        pass_reg    <= '0;
                        addr_1_reg  <= '0;
                        addr_2_reg  <= '0;
                        valid_1_reg <= 1'b0;
                        valid_2_reg <= 1'b0;
                        last_reg    <= 1'b0;
                    end else if (accept) begin
                        if (last_reg) begin
                            pass_reg <= pass_reg + PASS_W'(1);
                        end
                        addr_1_reg  <= gen_addr_1;
                        addr_2_reg  <= gen_addr_2;
                        valid_1_reg <= gen_valid_1;
                        valid_2_reg <= gen_valid_2;
                        last_reg    <= gen_last;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign addr_1_out          = addr_1_reg;
    assign addr_2_out          = addr_2_reg;
    assign package_1_valid_out = valid_1_reg;
    assign package_2_valid_out = valid_2_reg;
    assign last_out            = last_reg;
    assign pass_idx_out        = pass_reg;
    assign busy                = busy_reg;
    assign done                = done_reg;
endmodule

// File: tb/tb_data_mem_read_sched.sv
// Scoreboard bench for data_mem_read_sched: expected packages come from a plain loop over
// passes and tile pairs; a negedge monitor pops and compares every accepted package.
module tb_data_mem_read_sched;
    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] cfg_base;
    logic [7:0] cfg_num_tiles;
    logic [3:0] cfg_num_passes;
    logic       scan_mode;
    logic       ready_in;
    logic [7:0] addr_1_out;
    logic [7:0] addr_2_out;
    logic       package_1_valid_out;
    logic       package_2_valid_out;
    logic       last_out;
    logic [3:0] pass_idx_out;
    logic       busy;
    logic       done;

    typedef struct packed {
        logic [7:0] a1;
        logic [7:0] a2;
        logic       v1;
        logic       v2;
        logic       last;
        logic [3:0] pass;
    } pkg_t;

    pkg_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    data_mem_read_sched dut (
        .clk                 (clk),
        .reset               (reset),
        .start               (start),
        .cfg_base            (cfg_base),
        .cfg_num_tiles       (cfg_num_tiles),
        .cfg_num_passes      (cfg_num_passes),
        .scan_mode           (scan_mode),
        .ready_in            (ready_in),
        .addr_1_out          (addr_1_out),
        .addr_2_out          (addr_2_out),
        .package_1_valid_out (package_1_valid_out),
        .package_2_valid_out (package_2_valid_out),
        .last_out            (last_out),
        .pass_idx_out        (pass_idx_out),
        .busy                (busy),
        .done                (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s", name);
    endtask

    // Reference: each pass walks tiles in pairs; an odd tail is a single-port package.
    function automatic int push_job(input int base, input int tiles, input int passes);
        int   n = 0;
        pkg_t e;
        for (int p = 0; p < passes; p++) begin
            for (int c = 0; c < tiles; c += 2) begin
                int rem = tiles - c;
                e.a1   = 8'((base + c) % 128);
                e.v1   = 1'b1;
                e.v2   = (rem >= 2);
                e.a2   = (rem >= 2) ? 8'((base + c + 1) % 128) : e.a1;
                e.last = (rem <= 2);
                e.pass = 4'(p);
                exp_q.push_back(e);
                n++;
            end
        end
        return n;
    endfunction

    function automatic pkg_t sample();
        pkg_t s;
        s = {addr_1_out, addr_2_out, package_1_valid_out, package_2_valid_out,
             last_out, pass_idx_out};
        return s;
    endfunction

    initial begin : monitor
        pkg_t cur;
        pkg_t prev;
        pkg_t e;
        bit   stall_pending;
        stall_pending = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                stall_pending = 1'b0;
            end else begin
                cur = sample();
                if (stall_pending) begin
                    check("hold_under_backpressure", 32'(cur), 32'(prev));
                end
                if (cur.v1 && ready_in && !scan_mode) begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_package");
                    end else begin
                        e = exp_q.pop_front();
                        $display("pkg a1=%0d a2=%0d v=%b%b last=%b pass=%0d",
                                 cur.a1, cur.a2, cur.v1, cur.v2, cur.last, cur.pass);
                        check("package", 32'(cur), 32'(e));
                    end
                end
                stall_pending = cur.v1 && !ready_in && !scan_mode;
                prev = cur;
            end
        end
    end

    function automatic logic [31:0] all_outs();
        return {addr_1_out, addr_2_out, package_1_valid_out, package_2_valid_out,
                last_out, pass_idx_out, busy, done};
    endfunction

    task automatic pulse_start(input int base, input int tiles, input int passes);
        cfg_base       = 8'(base);
        cfg_num_tiles  = 8'(tiles);
        cfg_num_passes = 4'(passes);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cfg_base       = 8'($urandom);
        cfg_num_tiles  = 8'($urandom);
        cfg_num_passes = 4'($urandom);
    endtask

    // mode 0: always ready, 1: random ready, 2: ready low for 3 cycles on the 2nd package
    task automatic run_job(input int base, input int tiles, input int passes, input int mode);
        int npk;
        int cyc;
        npk = push_job(base, tiles, passes);
        ready_in = 1'b1;
        pulse_start(base, tiles, passes);
        check("busy_after_start", 32'(busy), 32'd1);
        cyc = 0;
        while (!done && cyc < 4000) begin
            case (mode)
                0:       ready_in = 1'b1;
                1:       ready_in = ($urandom_range(0, 3) != 0);
                default: ready_in = !(cyc >= 1 && cyc <= 3);
            endcase
            @(posedge clk);
            #1;
            cyc++;
            if (mode == 2 && cyc == 3) begin
                check("stall_pair", {16'd0, addr_1_out, addr_2_out}, {16'd0, 8'd2, 8'd3});
            end
        end
        if (!done) begin
            fail_now("done_timeout");
            exp_q.delete();
        end else begin
            $display("job base=%0d tiles=%0d passes=%0d done after %0d cycles",
                     base, tiles, passes, cyc);
            check("done_busy", 32'(busy), 32'd1);
            check("done_valids", {30'd0, package_1_valid_out, package_2_valid_out}, 32'd0);
            if (mode == 0) begin
                check("no_bubble_latency", 32'(cyc), 32'(npk));
            end
            check("queue_drained", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
            @(posedge clk);
            #1;
            check("done_one_cycle", 32'(done), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
        end
    endtask

    initial begin : stimulus
        int n;
        reset = 1'b1;
        start = 1'b0;
        scan_mode = 1'b0;
        ready_in = 1'b0;
        cfg_base = '0;
        cfg_num_tiles = '0;
        cfg_num_passes = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", all_outs(), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        run_job(0, 4, 1, 0);
        run_job(10, 3, 2, 0);
        run_job(126, 4, 1, 0);
        run_job(0, 6, 1, 2);
        run_job(40, 0, 3, 0);
        run_job(40, 5, 0, 0);
        run_job(0, 128, 1, 0);

        // abort by scan_mode while the 2nd package is presented
        n = push_job(20, 8, 1);
        ready_in = 1'b1;
        pulse_start(20, 8, 1);
        @(posedge clk);
        #1;
        check("abort_second_pkg", 32'(addr_1_out), 32'd22);
        scan_mode = 1'b1;
        @(posedge clk);
        #1;
        scan_mode = 1'b0;
        check("abort_outputs", {29'd0, package_1_valid_out, package_2_valid_out, last_out}, 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_remaining", 32'(exp_q.size()), 32'(n - 1));
        exp_q.delete();
        repeat (4) begin
            @(posedge clk);
            #1;
            check("abort_no_done", 32'(done), 32'd0);
        end

        // start while scan-loading is ignored
        scan_mode = 1'b1;
        pulse_start(0, 4, 1);
        check("scan_start_busy", 32'(busy), 32'd0);
        check("scan_start_valid", 32'(package_1_valid_out), 32'd0);
        @(posedge clk);
        #1;
        check("scan_start_no_done", 32'(done), 32'd0);
        scan_mode = 1'b0;

        // reset mid-run, then a clean rerun
        n = push_job(5, 10, 2);
        ready_in = 1'b1;
        pulse_start(5, 10, 2);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrun_reset_outputs", all_outs(), 32'd0);
        reset = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        run_job(5, 10, 2, 0);

        for (int j = 0; j < 20; j++) begin
            int tiles;
            tiles = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 128))
                                                 : int'($urandom_range(0, 12));
            run_job(int'($urandom_range(0, 255)), tiles, int'($urandom_range(0, 3)), 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
